// File: rtl/exc_pc_arbiter_if.sv
// PC-path / exception bundle between main control, PC mux, EPC and memory.
// The arbiter uses the slave side; the surrounding core uses master.
interface exc_pc_arbiter_if;
    logic [2:0]  exc_req;
    logic [31:0] pc_in;
    logic [2:0]  ctrl_pc_sel;
    logic        ctrl_pc_we;
    logic [7:0]  mem_rdata;
    logic [2:0]  pc_src_sel;
    logic        pc_we;
    logic [31:0] handler_pc;
    logic        epc_we;
    logic [31:0] epc_data;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [1:0]  cause;
    logic        stall;
    logic        exc_done;

    modport slave (
        input  exc_req, pc_in, ctrl_pc_sel, ctrl_pc_we, mem_rdata,
        output pc_src_sel, pc_we, handler_pc, epc_we, epc_data,
        output mem_rd, mem_addr, cause, stall, exc_done
    );

    modport master (
        output exc_req, pc_in, ctrl_pc_sel, ctrl_pc_we, mem_rdata,
        input  pc_src_sel, pc_we, handler_pc, epc_we, epc_data,
        input  mem_rd, mem_addr, cause, stall, exc_done
    );
endinterface

// File: rtl/exc_pc_arbiter.sv
// Exception sequencer: saves EPC, fetches vector byte, loads PC, then returns.
// Optional macro EXC_PENDING_EN queues causes that arrive while busy.
module exc_pc_arbiter #(
    parameter logic [31:0] VEC_BASE = 32'd253,
    parameter logic [2:0]  EXC_SEL  = 3'b110
) (
    input logic             clk,
    input logic             reset_n,
    exc_pc_arbiter_if.slave bus
);

    typedef enum logic [2:0] {IDLE, SAVE, FETCH, LOAD, COMMIT} state_t;

    state_t      stateQ, stateD;
    logic [1:0]  causeQ, causeD;
    logic [31:0] handlerQ;

`ifdef EXC_PENDING_EN
    logic [2:0]  pendQ, pendD, pendAll;
`endif

    // Lowest set bit wins: invalid opcode, then overflow, then div-by-zero.
    function automatic logic [1:0] pickCause(input logic [2:0] req);
        if (req[0])      return 2'd0;
        else if (req[1]) return 2'd1;
        else             return 2'd2;
    endfunction

`ifdef EXC_PENDING_EN
    function automatic logic [2:0] causeBit(input logic [1:0] c);
        return 3'b001 << c;
    endfunction
`endif

    always_comb begin
        stateD         = stateQ;
        causeD         = causeQ;
        bus.pc_src_sel = EXC_SEL;
        bus.pc_we      = 1'b0;
        bus.epc_we     = 1'b0;
        bus.epc_data   = bus.pc_in - 32'd4;
        bus.mem_rd     = 1'b0;
        bus.mem_addr   = VEC_BASE + {30'd0, causeQ};
        bus.stall      = 1'b1;
        bus.exc_done   = 1'b0;
`ifdef EXC_PENDING_EN
        pendAll        = pendQ | bus.exc_req;
        pendD          = pendQ;
`endif
        unique case (stateQ)
            IDLE: begin
                bus.pc_src_sel = bus.ctrl_pc_sel;
                bus.pc_we      = bus.ctrl_pc_we;
                bus.stall      = 1'b0;
                if (bus.exc_req != 3'd0) begin
                    stateD = SAVE;
                    causeD = pickCause(bus.exc_req);
`ifdef EXC_PENDING_EN
                    pendD  = bus.exc_req & ~causeBit(causeD);
`endif
                end
            end
            SAVE: begin
                bus.epc_we = 1'b1;
                stateD     = FETCH;
`ifdef EXC_PENDING_EN
                pendD      = pendAll;
`endif
            end
            FETCH: begin
                bus.mem_rd = 1'b1;
                stateD     = LOAD;
`ifdef EXC_PENDING_EN
                pendD      = pendAll;
`endif
            end
            LOAD: begin
                stateD = COMMIT;
`ifdef EXC_PENDING_EN
                pendD  = pendAll;
`endif
            end
            COMMIT: begin
                bus.pc_we    = 1'b1;
                bus.exc_done = 1'b1;
                stateD       = IDLE;
`ifdef EXC_PENDING_EN
                pendD        = 3'd0;
                if (pendAll != 3'd0) begin
                    stateD = SAVE;
                    causeD = pickCause(pendAll);
                    pendD  = pendAll & ~causeBit(causeD);
                end
`endif
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ   <= IDLE;
            causeQ   <= 2'd0;
            handlerQ <= 32'd0;
        end else begin
            stateQ <= stateD;
            causeQ <= causeD;
            if (stateQ == LOAD)
                handlerQ <= {24'd0, bus.mem_rdata};
        end
    end

`ifdef EXC_PENDING_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pendQ <= 3'd0;
        else          pendQ <= pendD;
    end
`endif

    assign bus.cause      = causeQ;
    assign bus.handler_pc = handlerQ;

endmodule

// File: tb/tb_exc_pc_arbiter.sv
// Directed bench for exc_pc_arbiter with a small vector-table memory.
// Also covers the EXC_PENDING_EN build when the macro is defined.
module tb_exc_pc_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    int   nVec = 0;
    int   nErr = 0;

    exc_pc_arbiter_if bus();

    exc_pc_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Byte memory with one-cycle read latency.
    logic [7:0] vecMem [0:255];
    always @(posedge clk)
        if (bus.mem_rd) bus.mem_rdata <= vecMem[bus.mem_addr[7:0]];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [2:0] req);
        @(negedge clk);
        bus.exc_req = req;
        #1;
    endtask

    int stalls;
    int k;
    int dones;
    logic [31:0] expA [3];

    initial begin
        for (int i = 0; i < 256; i++) vecMem[i] = 8'h00;
        vecMem[253] = 8'h5A;
        vecMem[254] = 8'h7C;
        vecMem[255] = 8'hA3;
        expA[0] = 32'd253;
        expA[1] = 32'd254;
        expA[2] = 32'd255;

        reset_n         = 1'b0;
        bus.exc_req     = 3'd0;
        bus.pc_in       = 32'h40;
        bus.ctrl_pc_sel = 3'b101;
        bus.ctrl_pc_we  = 1'b1;
        bus.mem_rdata   = 8'h00;
        #3;
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_sel", 32'(bus.pc_src_sel), 32'd5);
        chk("rst_we", 32'(bus.pc_we), 32'd1);
        chk("rst_hpc", bus.handler_pc, 32'd0);
        chk("rst_cause", 32'(bus.cause), 32'd0);
        chk("rst_strobes",
            {29'd0, bus.epc_we, bus.mem_rd, bus.exc_done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic overflow sequence, PC write same cycle as request
        step(3'b010);
        chk("t1c0_we", 32'(bus.pc_we), 32'd1);
        chk("t1c0_stall", 32'(bus.stall), 32'd0);
        step(3'b000);
        chk("t1c1_stall", 32'(bus.stall), 32'd1);
        chk("t1c1_epcwe", 32'(bus.epc_we), 32'd1);
        chk("t1c1_epc", bus.epc_data, 32'h3C);
        chk("t1c1_we", 32'(bus.pc_we), 32'd0);
        chk("t1c1_cause", 32'(bus.cause), 32'd1);
        chk("t1c1_sel", 32'(bus.pc_src_sel), 32'd6);
        step(3'b000);
        chk("t1c2_rd", 32'(bus.mem_rd), 32'd1);
        chk("t1c2_addr", bus.mem_addr, 32'd254);
        chk("t1c2_epcwe", 32'(bus.epc_we), 32'd0);
        step(3'b000);
        chk("t1c3_stall", 32'(bus.stall), 32'd1);
        chk("t1c3_rd", 32'(bus.mem_rd), 32'd0);
        chk("t1c3_we", 32'(bus.pc_we), 32'd0);
        step(3'b000);
        chk("t1c4_we", 32'(bus.pc_we), 32'd1);
        chk("t1c4_sel", 32'(bus.pc_src_sel), 32'd6);
        chk("t1c4_hpc", bus.handler_pc, 32'h7C);
        chk("t1c4_done", 32'(bus.exc_done), 32'd1);
        chk("t1c4_stall", 32'(bus.stall), 32'd1);
        step(3'b000);
        chk("t1c5_stall", 32'(bus.stall), 32'd0);
        chk("t1c5_done", 32'(bus.exc_done), 32'd0);
        chk("t1c5_sel", 32'(bus.pc_src_sel), 32'd5);
        chk("t1c5_hpc", bus.handler_pc, 32'h7C);

        // All three causes at once
        step(3'b111);
        stalls = 0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            step(3'b000);
            if (!bus.stall) break;
            if (i == 0) chk("t2_cause", 32'(bus.cause), 32'd0);
            stalls++;
            if (bus.mem_rd) begin
                if (k < 3) chk("t2_addr", bus.mem_addr, expA[k]);
                k++;
            end
        end
`ifdef EXC_PENDING_EN
        chk("t2_stalls", stalls, 32'd12);
        chk("t2_fetches", k, 32'd3);
        chk("t2_hpc", bus.handler_pc, 32'hA3);
`else
        chk("t2_stalls", stalls, 32'd4);
        chk("t2_fetches", k, 32'd1);
        chk("t2_hpc", bus.handler_pc, 32'h5A);
`endif

        // EPC wrap at pc_in = 0, divide-by-zero vector
        bus.pc_in = 32'd0;
        step(3'b100);
        step(3'b000);
        chk("t3_epc", bus.epc_data, 32'hFFFFFFFC);
        chk("t3_cause", 32'(bus.cause), 32'd2);
        step(3'b000);
        chk("t3_addr", bus.mem_addr, 32'd255);
        step(3'b000);
        step(3'b000);
        chk("t3_hpc", bus.handler_pc, 32'hA3);
        step(3'b000);
        chk("t3_idle", 32'(bus.stall), 32'd0);

`ifndef EXC_PENDING_EN
        // Request arriving in FETCH is dropped
        bus.pc_in = 32'h40;
        bus.ctrl_pc_sel = 3'b011;
        step(3'b010);
        step(3'b000);
        step(3'b001);
        step(3'b000);
        step(3'b000);
        chk("t4_done", 32'(bus.exc_done), 32'd1);
        step(3'b000);
        chk("t4_stall", 32'(bus.stall), 32'd0);
        chk("t4_sel", 32'(bus.pc_src_sel), 32'd3);
        step(3'b000);
        chk("t4_stay", 32'(bus.stall), 32'd0);
`endif

        // Reset during LOAD
        bus.ctrl_pc_we = 1'b1;
        bus.ctrl_pc_sel = 3'b101;
        step(3'b010);
        step(3'b000);
        step(3'b000);
        step(3'b000);
        chk("t5_load", 32'(bus.stall), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_stall", 32'(bus.stall), 32'd0);
        chk("t5_done", 32'(bus.exc_done), 32'd0);
        chk("t5_hpc", bus.handler_pc, 32'd0);
        chk("t5_we", 32'(bus.pc_we), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            step(3'b000);
            if (bus.exc_done || bus.stall) dones++;
        end
        chk("t5_nocommit", dones, 32'd0);

        // Idle passthrough
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            step(3'b000);
            if (bus.pc_src_sel != 3'b101 || !bus.pc_we || bus.stall)
                dones++;
        end
        chk("t6_pass", dones, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/exc_pc_arbiter.md
# exc_pc_arbiter

Exception sequencer and PC-path arbiter for the multicycle MIPS core. It sits between the main control unit and the 7-input, 3-bit-select PC source multiplexer. When the main control raises an exception cause, the block takes ownership of the PC mux select and the PC write enable. It saves EPC, fetches the handler byte from the vector table in memory and loads it into PC. It then hands PC control back to the main control.

## Interface
- `VEC_BASE`, default 253: byte address of the vector table; entry address = `VEC_BASE` + cause index.
- `EXC_SEL`, default 3'b110: PC mux select code of the input wired to `handler_pc`.
- `clk` in 1: core clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `exc_req` in 3: cause strobes from the main control, sampled each cycle. Bit 0 = invalid opcode, bit 1 = overflow, bit 2 = divide by zero.
- `pc_in` in 32: current PC register value.
- `ctrl_pc_sel` in 3: PC mux select requested by the main control.
- `ctrl_pc_we` in 1: PC write requested by the main control.
- `mem_rdata` in 8: memory read byte, valid the cycle after `mem_rd`.
- `pc_src_sel` out 3: select driven to the PC mux.
- `pc_we` out 1: PC register write enable.
- `handler_pc` out 32: handler address; drives PC mux input `EXC_SEL`.
- `epc_we` out 1: EPC register write enable.
- `epc_data` out 32: value written to EPC.
- `mem_rd` out 1: memory read strobe.
- `mem_addr` out 32: memory address; valid only while `mem_rd`=1.
- `cause` out 2: index of the cause being or last serviced.
- `stall` out 1: main control must hold its state while high.
- `exc_done` out 1: one-cycle pulse when the handler PC is committed.

## Operation
- States and transitions:
  - IDLE → SAVE, when `exc_req`≠0.
  - SAVE → FETCH.
  - FETCH → LOAD.
  - LOAD → COMMIT.
  - COMMIT → IDLE, or COMMIT → SAVE when a pending cause remains (see Configuration).
- Cause priority, highest first: bit 0 (index 0), then bit 1 (index 1), then bit 2 (index 2). `cause` is registered on the IDLE→SAVE edge.
- IDLE:
  - `pc_src_sel`=`ctrl_pc_sel` and `pc_we`=`ctrl_pc_we`, combinational passthrough.
  - `stall`=0.
- SAVE:
  - `epc_we`=1 and `epc_data`=`pc_in` − 4, arithmetic mod 2^32 (`pc_in`=0 gives 32'hFFFFFFFC).
  - `pc_we`=0.
- FETCH:
  - `mem_rd`=1 and `mem_addr`=`VEC_BASE`+`cause`, 32-bit add.
  - `pc_we`=0.
- LOAD: `handler_pc` is registered as {24'b0, `mem_rdata`} at the end of the cycle; `pc_we`=0.
- COMMIT:
  - `pc_src_sel`=`EXC_SEL` and `pc_we`=1.
  - `exc_done`=1.
- `stall`=1 in SAVE, FETCH, LOAD and COMMIT. `ctrl_pc_sel` and `ctrl_pc_we` are ignored in those states.
- In non-IDLE states `pc_src_sel`=`EXC_SEL`.
- `epc_we`, `mem_rd` and `exc_done` are 0 outside their named states.
- `handler_pc` holds its value between exceptions.
- Reset, asynchronous and valid mid-sequence:
  - State goes to IDLE; `cause`=0, `handler_pc`=0 and the pending register is cleared.
  - `epc_we`, `mem_rd`, `stall` and `exc_done` are 0.
  - `pc_src_sel` and `pc_we` follow the control inputs.
  - An interrupted sequence is abandoned: EPC keeps whatever was written and PC is not loaded.

## Timing
- Causes are sampled in IDLE on cycle 0.
- SAVE is cycle 1, FETCH cycle 2, LOAD cycle 3 (memory byte captured) and COMMIT cycle 4 (PC written).
- Back in IDLE on cycle 5, with fixed 4 cycles of `stall`.
- The PC holds the handler address from cycle 5.
- A new `exc_req` in the COMMIT cycle is treated as arriving while busy.
- `exc_req` in the same IDLE cycle as `ctrl_pc_we`=1: the main-control PC write in that cycle still occurs (passthrough), and the exception starts next cycle.

## Configuration
- `EXC_PENDING_EN` defined:
  - `exc_req` bits arriving in SAVE through COMMIT are OR-ed into a 3-bit pending register.
  - In COMMIT, if pending≠0, the next state is SAVE with the highest-priority pending cause, and that bit is cleared.
  - The new EPC is computed from `pc_in` in that SAVE cycle, which is the freshly loaded handler PC.
- `EXC_PENDING_EN` undefined: no pending register; `exc_req` outside IDLE is discarded; COMMIT always goes to IDLE.

## Test plan
- Reset then `exc_req`=3'b010, `pc_in`=32'h40, vector byte at address 254 = 8'h7C → `epc_data`=32'h3C with `epc_we` in cycle 1, `mem_addr`=254 in cycle 2, `pc_we`=1/`pc_src_sel`=3'b110/`handler_pc`=32'h7C/`exc_done` in cycle 4, `stall` high exactly cycles 1–4.
- `exc_req`=3'b111 → `cause`=0, `mem_addr`=253; with `EXC_PENDING_EN` the sequence repeats for cause 1 then cause 2 (addresses 254, 255), 12 stall cycles total. Without the macro there is one sequence only.
- `pc_in`=0 with `exc_req`=3'b100 → `epc_data`=32'hFFFFFFFC, `mem_addr`=255.
- `exc_req`=3'b001 arriving in FETCH (no macro) → ignored; after COMMIT the block is IDLE and `pc_src_sel` follows `ctrl_pc_sel`=3'b011.
- `reset_n` asserted low during LOAD → immediately `stall`=0, `exc_done`=0, `handler_pc`=0, and `pc_we` reflects `ctrl_pc_we`. No COMMIT occurs after release.
- IDLE with `ctrl_pc_sel`=3'b101 and `ctrl_pc_we`=1, no exception → outputs equal the inputs every cycle and `stall`=0.
